// File: rtl/tcp_segment_buffer.sv
// rtl/tcp_segment_buffer.sv - single-segment TCP store, checksum patch and replay buffer
//
// Absorbs one TCP segment from the encoder (no backpressure on that side),
// patches the late checksum into word 4 bits [31:16] once fin rises, then
// replays the words over a valid/ready stream with last/keep qualifiers.
//
// Ports:
//   clk, reset       clock; synchronous active-low reset
//   in_wr_en/in_data encoder word strobe and word (byte 0 in [31:24])
//   in_fin           encoder done level; in_checksum/in_len valid while high
//   out_data/out_valid/out_ready/out_last/out_keep  replay stream
//   out_len          latched segment length in bytes
//   busy             high outside IDLE
//   err              sticky error (overflow, length mismatch, short segment,
//                    late write); cleared on DONE->IDLE
//
// Build option: TCP_SEG_BUF_ZERO_PAD_EN zeroes last-word bytes not enabled by out_keep.

module tcp_segment_buffer #(
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_wr_en,
  input  logic [31:0] in_data,
  input  logic        in_fin,
  input  logic [15:0] in_checksum,
  input  logic [15:0] in_len,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  out_keep,
  output logic [15:0] out_len,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PATCH_IDX = {{(ADDR_W-2){1'b0}}, 3'd4};

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [ADDR_W:0] wcnt_q;
  logic [ADDR_W:0] nwords_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic            ovf_q;
  logic            fin_prev_q;
  logic            err_q;
  logic [15:0]     csum_q;
  logic [15:0]     len_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic            patch_q;
  logic [3:0]      keep_q;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata_q;

  logic            fin_rise;
  logic            full;
  logic            mem_we;
  logic            load;
  logic            accept;
  logic            ovf_d;
  logic [ADDR_W:0] wcnt_d;
  logic [16:0]     exp_words;
  logic [3:0]      last_keep;

  assign fin_rise  = in_fin & ~fin_prev_q;
  assign full      = (wcnt_q == FULL_CNT);
  assign mem_we    = in_wr_en & ((state_q == IDLE) | ((state_q == FILL) & ~full));
  assign wcnt_d    = mem_we ? (wcnt_q + ONE) : wcnt_q;
  assign ovf_d     = ovf_q | ((state_q == FILL) & in_wr_en & full);
  assign exp_words = ({1'b0, in_len} + 17'd3) >> 2;
  assign accept    = out_valid_q & out_ready;
  // Fetch the next word whenever the output register is empty or being
  // emptied this cycle; this gives one word per cycle with no bubbles.
  assign load      = (state_q == DRAIN) & (rd_ptr_q != nwords_q) & (~out_valid_q | out_ready);

  always_comb begin
    last_keep = 4'b1111;
    case (len_q[1:0])
      2'd1:    last_keep = 4'b1000;
      2'd2:    last_keep = 4'b1100;
      2'd3:    last_keep = 4'b1110;
      default: last_keep = 4'b1111;
    endcase
  end

  // Segment storage: write port from the encoder, registered read port that
  // doubles as the output data register (only advances on load).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wcnt_q[ADDR_W-1:0]] <= in_data;
    end
    if (load) begin
      rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      nwords_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      fin_prev_q  <= 1'b0;
      err_q       <= 1'b0;
      csum_q      <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      patch_q     <= 1'b0;
      keep_q      <= '0;
    end else begin
      fin_prev_q <= in_fin;
      case (state_q)
        IDLE: begin
          ovf_q <= 1'b0;
          if (in_wr_en) begin
            wcnt_q  <= wcnt_d;
            state_q <= FILL;
          end
        end

        FILL: begin
          wcnt_q <= wcnt_d;
          ovf_q  <= ovf_d;
          if (fin_rise) begin
            // wcnt_d/ovf_d already include a coincident word
            csum_q   <= in_checksum;
            len_q    <= in_len;
            nwords_q <= wcnt_d;
            rd_ptr_q <= '0;
            if (ovf_d) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              if ((17'(wcnt_d) != exp_words) || (wcnt_d <= PATCH_IDX)) begin
                err_q <= 1'b1;
              end
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (in_wr_en) begin
            err_q <= 1'b1;
          end
          if (load) begin
            rd_ptr_q    <= rd_ptr_q + ONE;
            out_valid_q <= 1'b1;
            out_last_q  <= ((rd_ptr_q + ONE) == nwords_q);
            keep_q      <= ((rd_ptr_q + ONE) == nwords_q) ? last_keep : 4'b1111;
            patch_q     <= (rd_ptr_q == PATCH_IDX);
          end else if (accept) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            keep_q      <= '0;
            patch_q     <= 1'b0;
          end
          if (accept && out_last_q) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          if (in_wr_en) begin
            err_q <= 1'b1;
          end
          if (!in_fin) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid_q) begin
      out_data = rdata_q;
      if (patch_q) begin
        out_data[31:16] = csum_q;
      end
`ifdef TCP_SEG_BUF_ZERO_PAD_EN
      out_data = out_data & {{8{keep_q[3]}}, {8{keep_q[2]}}, {8{keep_q[1]}}, {8{keep_q[0]}}};
`else
      out_data = out_data;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_keep  = keep_q;
  assign out_len   = len_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_tcp_segment_buffer.sv
// tb/tb_tcp_segment_buffer.sv - randomized self-checking bench for tcp_segment_buffer

module tb_tcp_segment_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_wr_en;
  logic [31:0] in_data;
  logic        in_fin;
  logic [15:0] in_checksum;
  logic [15:0] in_len;
  logic        out_ready;

  logic [31:0] b_data, s_data;
  logic        b_valid, s_valid, b_last, s_last, b_busy, s_busy, b_err, s_err;
  logic [3:0]  b_keep, s_keep;
  logic [15:0] b_len, s_len;

  logic        sel;
  logic [31:0] o_data;
  logic        o_valid, o_last, o_busy, o_err;
  logic [3:0]  o_keep;
  logic [15:0] o_len;

  assign o_data  = sel ? s_data  : b_data;
  assign o_valid = sel ? s_valid : b_valid;
  assign o_last  = sel ? s_last  : b_last;
  assign o_keep  = sel ? s_keep  : b_keep;
  assign o_len   = sel ? s_len   : b_len;
  assign o_busy  = sel ? s_busy  : b_busy;
  assign o_err   = sel ? s_err   : b_err;

  tcp_segment_buffer #(.ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .in_wr_en(in_wr_en), .in_data(in_data),
    .in_fin(in_fin), .in_checksum(in_checksum), .in_len(in_len),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
    .out_last(b_last), .out_keep(b_keep), .out_len(b_len),
    .busy(b_busy), .err(b_err)
  );

  tcp_segment_buffer #(.ADDR_W(4)) dut_small (
    .clk(clk), .reset(reset), .in_wr_en(in_wr_en), .in_data(in_data),
    .in_fin(in_fin), .in_checksum(in_checksum), .in_len(in_len),
    .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
    .out_last(s_last), .out_keep(s_keep), .out_len(s_len),
    .busy(s_busy), .err(s_err)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] wq[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_keep[$];

  // Reference: word i is stored word i, word 4 carries the checksum in its
  // upper half, the last word keeps the top (len mod 4) bytes.
  task automatic build_model(input int len, input logic [15:0] csum);
    exp_data.delete();
    exp_keep.delete();
    for (int i = 0; i < wq.size(); i++) begin
      logic [31:0] w;
      logic [3:0]  k;
      w = wq[i];
      k = 4'hF;
      if (i == 4) w[31:16] = csum;
      if (i == wq.size() - 1) begin
        case (len % 4)
          1: k = 4'b1000;
          2: k = 4'b1100;
          3: k = 4'b1110;
          default: k = 4'b1111;
        endcase
      end
`ifdef TCP_SEG_BUF_ZERO_PAD_EN
      for (int b = 0; b < 4; b++) if (!k[b]) w[b*8 +: 8] = 8'h00;
`endif
      exp_data.push_back(w);
      exp_keep.push_back(k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_segment(input int len, input logic [15:0] csum, input bit coincide);
    for (int i = 0; i < wq.size(); i++) begin
      in_wr_en = 1'b1;
      in_data  = wq[i];
      if (coincide && i == wq.size() - 1) begin
        in_fin = 1'b1; in_checksum = csum; in_len = 16'(len);
      end
      tick();
    end
    in_wr_en = 1'b0;
    in_data  = '0;
    in_fin = 1'b1; in_checksum = csum; in_len = 16'(len);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    out_ready = 1'b1;
    in_fin    = 1'b0;
    cyc = 0;
    while ((b_busy || s_busy) && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (b_busy || s_busy) begin
      errors++;
      $display("FAIL %s idle_timeout: busy=%b/%b required 0/0", name, b_busy, s_busy);
    end
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL %s err_clear: err=%b required 0", name, o_err);
    end
  endtask

  task automatic drain_check(input string name, input int mode, input bit late_wr,
                             input bit exp_err, input int len, input int exp_lat);
    int n, got, cyc, first_cyc;
    bit stalled, rdy;
    logic [36:0] held;
    n = exp_data.size();
    got = 0; cyc = 0; first_cyc = -1; stalled = 0; held = '0;
    while (got < n && cyc < 600) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      in_wr_en  = late_wr && (cyc == 3);
      in_data   = $urandom;
      if (o_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          checks++;
          if (first_cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: first valid at %0d required %0d", name, first_cyc, exp_lat);
          end
          checks++;
          if (o_len !== 16'(len)) begin
            errors++;
            $display("FAIL %s out_len: got %0d required %0d", name, o_len, len);
          end
        end
        if (stalled) begin
          checks++;
          if ({o_data, o_last, o_keep} !== held) begin
            errors++;
            $display("FAIL %s stall_hold: got %h required %h", name, {o_data, o_last, o_keep}, held);
          end
        end
        if (rdy) begin
          checks++;
          if (o_data !== exp_data[got] || o_last !== (got == n - 1) || o_keep !== exp_keep[got]) begin
            errors++;
            $display("FAIL %s word%0d: data=%h last=%b keep=%b required data=%h last=%b keep=%b",
                     name, got, o_data, o_last, o_keep, exp_data[got], (got == n - 1), exp_keep[got]);
          end
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {o_data, o_last, o_keep};
        end
      end else if (got > 0 || stalled) begin
        checks++;
        errors++;
        $display("FAIL %s valid_gap: valid=0 after %0d of %0d words", name, got, n);
      end
      tick();
      cyc++;
    end
    in_wr_en = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s drain_timeout: got %0d words required %0d", name, got, n);
    end
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL %s end_of_segment: valid=%b last=%b required 0 0", name, o_valid, o_last);
    end
    checks++;
    if (o_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b required %b", name, o_err, exp_err);
    end
  endtask

  task automatic run_segment(input string name, input int len, input logic [15:0] csum,
                             input int mode, input bit late_wr, input bit coincide);
    bit exp_err;
    int n;
    n = wq.size();
    build_model(len, csum);
    exp_err = (n != (len + 3) / 4) || (n <= 4) || late_wr;
    send_segment(len, csum, coincide);
    drain_check(name, mode, late_wr, exp_err, len, coincide ? 1 : 2);
    wait_idle(name);
  endtask

  task automatic fill_basic(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back((i == 4) ? 32'h0000_0077 : 32'h0001_0000 + i);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_wr_en = 0; in_data = 0; in_fin = 0; in_checksum = 0; in_len = 0;
    out_ready = 0; sel = 0;
    tick(); tick();
    reset = 1'b1;
    checks++;
    if ({b_data, b_valid, b_last, b_keep, b_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b last=%b keep=%b len=%h required all 0",
               b_data, b_valid, b_last, b_keep, b_len);
    end
    checks++;
    if (b_busy !== 1'b0 || b_err !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b err=%b small_busy=%b required 0", b_busy, b_err, s_busy);
    end
  endtask

  task automatic test_basic();
    fill_basic(11);
    run_segment("basic", 44, 16'hBEEF, 0, 0, 0);
  endtask

  task automatic test_odd_length();
    fill_basic(11);
    wq.push_back(32'hAABB_CCDD);
    run_segment("odd_len", 45, 16'h1234, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    fill_basic(11);
    run_segment("backpressure", 44, 16'hBEEF, 1, 0, 0);
  endtask

  task automatic test_overflow();
    int seen;
    sel = 1'b1;
    wq.delete();
    for (int i = 0; i < 20; i++) wq.push_back(32'hC000_0000 + i);
    out_ready = 1'b1;
    send_segment(80, 16'h5555, 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (s_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL overflow_no_output: valid cycles=%0d required 0", seen);
    end
    checks++;
    if (s_err !== 1'b1 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: err=%b busy=%b required 1 1", s_err, s_busy);
    end
    wait_idle("overflow");
    sel = 1'b0;
  endtask

  task automatic test_len_mismatch_late_write();
    fill_basic(10);
    run_segment("len_mismatch", 44, 16'hCAFE, 0, 1, 0);
    fill_basic(11);
    run_segment("late_write", 44, 16'hCAFE, 2, 1, 0);
  endtask

  task automatic test_reset_mid_drain();
    int got, cyc;
    fill_basic(11);
    out_ready = 1'b1;
    send_segment(44, 16'hBEEF, 0);
    got = 0; cyc = 0;
    while (!(o_valid && got == 5) && cyc < 100) begin
      if (o_valid) got++;
      tick();
      cyc++;
    end
    reset = 1'b0;
    in_fin = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (b_valid !== 1'b0 || b_busy !== 1'b0 || b_err !== 1'b0 || b_last !== 1'b0 ||
        b_keep !== 4'h0 || b_len !== 16'h0 || b_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_drain: valid=%b busy=%b err=%b last=%b keep=%b len=%h data=%h required all 0",
               b_valid, b_busy, b_err, b_last, b_keep, b_len, b_data);
    end
    wq.delete();
    for (int i = 0; i < 9; i++) wq.push_back($urandom);
    run_segment("after_reset", 35, 16'h0F0F, 0, 0, 0);
  endtask

  task automatic test_random();
    int n, len, mode;
    bit coincide;
    for (int it = 0; it < 10; it++) begin
      n = (it == 0) ? 130 : $urandom_range(1, 24);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      if ($urandom_range(0, 3) != 0) len = n * 4 - $urandom_range(0, 3);
      else len = $urandom_range(1, 120);
      mode = $urandom_range(0, 2);
      coincide = (n >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_segment($sformatf("random%0d", it), len, 16'($urandom), mode, 0, coincide);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_backpressure();
    test_overflow();
    test_len_mismatch_late_write();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
